regfile_fwd: RTL and testbench
==============================

# regfile_fwd

Register file with a read-side forwarding network and a load scoreboard. It consumes the writeback port and the one-cycle-late virtual-writeback port, and presents registered source operands at the ID/EX boundary. It sits between decode and execute. It raises a hazard request when a source register still awaits an outstanding load.

## Interface
- No parameters; data width fixed at 32, 32 architectural registers, r0 hardwired to zero.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline stall; freezes latched read addresses and scoreboard issue.
- i_rs1, i_rs2  in  5  source register addresses from decode.
- i_rd_valid  in  1  decode holds a valid instruction; qualifies hazard detection.
- i_issue_load  in  1  decode issues a load this cycle.
- i_issue_rdst  in  5  destination of that load.
- i_wb_rdst  in  5  writeback destination register.
- i_wb_reg_write_rf  in  1  writeback write enable.
- i_wb_mux  in  32  writeback data.
- i_vwb_rdst  in  5  virtual-writeback destination, one cycle after WB.
- i_vwb_reg_write_rf  in  1  virtual-writeback enable.
- i_vwb_mux  in  32  virtual-writeback data.
- o_rs1_data, o_rs2_data  out  32  registered operands.
- o_rs1_fwd, o_rs2_fwd  out  2  registered source code: 0 array, 1 WB, 2 VWB, 3 zero (r0).
- o_hazard  out  1  combinational stall request: a load-use dependency is pending.

## Operation
- Storage: 31 x 32-bit array for r1..r31. Write on posedge when i_wb_reg_write_rf and i_wb_rdst != 0. Writes to r0 are discarded.
- Address latch: rs1_q/rs2_q load i_rs1/i_rs2 when !stall and hold when stall.
- Operand select per port, evaluated every non-reset cycle from the effective address (i_rsX when !stall, rsX_q when stall). The first matching rule applies:
  1. address 0 -> 0, code 3.
  2. WB enabled and i_wb_rdst matches -> i_wb_mux, code 1.
  3. VWB enabled and i_vwb_rdst matches -> i_vwb_mux, code 2.
  4. otherwise -> array content, code 0.
- Data regs refresh every cycle, including during a stall, so a write landing mid-stall is reflected.
- Scoreboard: 32-bit pending vector; bit 0 is always 0.
  - Set bit i_issue_rdst when i_issue_load && !stall && i_issue_rdst != 0.
  - Clear bit i_wb_rdst when i_wb_reg_write_rf.
  - Same register set and cleared in one cycle -> set wins, because the new load is outstanding.
- o_hazard = i_rd_valid && any(i_rsX != 0 && pending[i_rsX] && !(i_wb_reg_write_rf && i_wb_rdst == i_rsX)). A same-cycle WB write satisfies the dependency through bypass.
- Hazard does not gate the block's own updates; the pipeline controller turns o_hazard into stall.

## Timing
- Read latency: address presented in cycle N with !stall -> operand valid on outputs after posedge ending N, stable through N+1.
- WB in the same cycle as the read -> forwarded (code 1), never stale.
- Write in cycle N-1 -> visible through VWB (code 2) in cycle N. WB priority covers the case where both match.
- Scoreboard set takes effect the cycle after issue; clear takes effect the same cycle for o_hazard via the WB term.
- Reset (any cycle, including mid-stall or with loads pending):
  - array, rs1_q, rs2_q, pending vector -> 0.
  - o_rs*_data -> 0, o_rs*_fwd -> 0.
  - o_hazard -> 0 while pending is clear.
  - Inputs during the reset cycle are ignored.

## Test plan
- Reset then read: assert rst 1 cycle, read r5/r7 -> data 0, fwd 0, o_hazard 0.
- Same-cycle bypass: WB writes r3=0xDEADBEEF while i_rs1=3 -> next cycle o_rs1_data=0xDEADBEEF, o_rs1_fwd=1. A later read of r3 with no writes -> code 0, same value.
- VWB vs WB priority: WB r4=0x11, VWB r4=0x22, read r4 -> 0x11, code 1. Drop WB -> 0x22, code 2.
- r0: WB writes r0=0xFFFFFFFF, read rs1=rs2=0 -> 0, code 3 on both ports.
- Load-use:
  - Issue load to r9, then decode rs2=9 with i_rd_valid -> o_hazard=1.
  - The cycle WB writes r9=0x1234 -> o_hazard=0 and operand 0x1234, code 1.
  - Simultaneous re-issue of a load to r9 keeps the bit set.
- Stall hold: latch rs1=6, raise stall, change i_rs1=8, WB writes r6=0x55 during stall -> o_rs1_data becomes 0x55 while addressing r6. A load issued during stall does not set pending.

Source files
------------

// File: rtl/regfile_fwd.sv
// Register file with a read-side forwarding network (WB and virtual-WB bypass)
// and a load scoreboard that raises a load-use hazard request toward decode.
module regfile_fwd (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic        i_rd_valid,
    input  logic        i_issue_load,
    input  logic [4:0]  i_issue_rdst,
    input  logic [4:0]  i_wb_rdst,
    input  logic        i_wb_reg_write_rf,
    input  logic [31:0] i_wb_mux,
    input  logic [4:0]  i_vwb_rdst,
    input  logic        i_vwb_reg_write_rf,
    input  logic [31:0] i_vwb_mux,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [1:0]  o_rs1_fwd,
    output logic [1:0]  o_rs2_fwd,
    output logic        o_hazard
);

    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WB    = 2'd1,
        SRC_VWB   = 2'd2,
        SRC_ZERO  = 2'd3
    } src_e;

    typedef struct packed {
        logic [31:0] data;
        src_e        src;
    } operand_t;

    logic [31:0] regs [1:31];
    logic [4:0]  rs1_q, rs2_q;
    logic [4:0]  rs1_eff, rs2_eff;
    logic [31:0] rs1_arr, rs2_arr;
    operand_t    rs1_sel, rs2_sel;
    logic [31:0] pending, pending_next;

    // Priority: r0, then the youngest producer (WB), then VWB, then the array.
    function automatic operand_t select_operand(
        input logic [4:0]  addr,
        input logic [31:0] arr_data,
        input logic        wb_en,
        input logic [4:0]  wb_rdst,
        input logic [31:0] wb_data,
        input logic        vwb_en,
        input logic [4:0]  vwb_rdst,
        input logic [31:0] vwb_data
    );
        operand_t op;
        if (addr == 5'd0) begin
            op = '{data: 32'd0, src: SRC_ZERO};
        end else if (wb_en && wb_rdst == addr) begin
            op = '{data: wb_data, src: SRC_WB};
        end else if (vwb_en && vwb_rdst == addr) begin
            op = '{data: vwb_data, src: SRC_VWB};
        end else begin
            op = '{data: arr_data, src: SRC_ARRAY};
        end
        return op;
    endfunction

    function automatic logic load_dep(
        input logic [4:0]  addr,
        input logic [31:0] pend,
        input logic        wb_en,
        input logic [4:0]  wb_rdst
    );
        return (addr != 5'd0) && pend[addr] && !(wb_en && wb_rdst == addr);
    endfunction

    // NOTE: the array is built from flops rather than a RAM macro so that reset
    // clears all architectural state in a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (i_wb_reg_write_rf && i_wb_rdst != 5'd0) begin
            regs[i_wb_rdst] <= i_wb_mux;
        end
    end

    // NOTE: state is written with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order between blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (!stall) begin
            rs1_q <= i_rs1;
            rs2_q <= i_rs2;
        end
    end

    // During a stall the latched addresses keep steering the mux, so a write
    // landing mid-stall still reaches the held operand.
    // NOTE: every combinational output is assigned on all paths to avoid latches.
    always_comb begin
        rs1_eff = stall ? rs1_q : i_rs1;
        rs2_eff = stall ? rs2_q : i_rs2;
        rs1_arr = (rs1_eff == 5'd0) ? 32'd0 : regs[rs1_eff];
        rs2_arr = (rs2_eff == 5'd0) ? 32'd0 : regs[rs2_eff];
        rs1_sel = select_operand(rs1_eff, rs1_arr, i_wb_reg_write_rf, i_wb_rdst, i_wb_mux,
                                 i_vwb_reg_write_rf, i_vwb_rdst, i_vwb_mux);
        rs2_sel = select_operand(rs2_eff, rs2_arr, i_wb_reg_write_rf, i_wb_rdst, i_wb_mux,
                                 i_vwb_reg_write_rf, i_vwb_rdst, i_vwb_mux);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_rs1_fwd  <= SRC_ARRAY;
            o_rs2_fwd  <= SRC_ARRAY;
        end else begin
            o_rs1_data <= rs1_sel.data;
            o_rs2_data <= rs2_sel.data;
            o_rs1_fwd  <= rs1_sel.src;
            o_rs2_fwd  <= rs2_sel.src;
        end
    end

    // Set is applied after clear so a re-issued load to the register being
    // written back stays outstanding.
    always_comb begin
        pending_next = pending;
        if (i_wb_reg_write_rf) begin
            pending_next[i_wb_rdst] = 1'b0;
        end
        if (i_issue_load && !stall && i_issue_rdst != 5'd0) begin
            pending_next[i_issue_rdst] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign o_hazard = i_rd_valid &&
                      (load_dep(i_rs1, pending, i_wb_reg_write_rf, i_wb_rdst) ||
                       load_dep(i_rs2, pending, i_wb_reg_write_rf, i_wb_rdst));

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: one table row per clock cycle, hazard sampled
// on the falling edge, registered operands sampled just after the rising edge.
module tb_regfile_fwd;

    logic        clk = 1'b1;
    logic        rst, stall, i_rd_valid, i_issue_load;
    logic [4:0]  i_rs1, i_rs2, i_issue_rdst, i_wb_rdst, i_vwb_rdst;
    logic        i_wb_reg_write_rf, i_vwb_reg_write_rf;
    logic [31:0] i_wb_mux, i_vwb_mux;
    logic [31:0] o_rs1_data, o_rs2_data;
    logic [1:0]  o_rs1_fwd, o_rs2_fwd;
    logic        o_hazard;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regfile_fwd dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .i_rs1             (i_rs1),
        .i_rs2             (i_rs2),
        .i_rd_valid        (i_rd_valid),
        .i_issue_load      (i_issue_load),
        .i_issue_rdst      (i_issue_rdst),
        .i_wb_rdst         (i_wb_rdst),
        .i_wb_reg_write_rf (i_wb_reg_write_rf),
        .i_wb_mux          (i_wb_mux),
        .i_vwb_rdst        (i_vwb_rdst),
        .i_vwb_reg_write_rf(i_vwb_reg_write_rf),
        .i_vwb_mux         (i_vwb_mux),
        .o_rs1_data        (o_rs1_data),
        .o_rs2_data        (o_rs2_data),
        .o_rs1_fwd         (o_rs1_fwd),
        .o_rs2_fwd         (o_rs2_fwd),
        .o_hazard          (o_hazard)
    );

    typedef struct {
        logic        rst, stall;
        logic [4:0]  rs1, rs2;
        logic        rd_valid, issue_load;
        logic [4:0]  issue_rdst;
        logic        wb_we;
        logic [4:0]  wb_rdst;
        logic [31:0] wb_data;
        logic        vwb_we;
        logic [4:0]  vwb_rdst;
        logic [31:0] vwb_data;
        logic        chk_haz, exp_haz;
        logic [31:0] exp_d1;
        logic [1:0]  exp_f1;
        logic [31:0] exp_d2;
        logic [1:0]  exp_f2;
    } vec_t;

    function automatic vec_t v(
        input logic rst_i, input logic stall_i, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic rdv, input logic ld, input logic [4:0] ld_rd,
        input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd,
        input logic vwe, input logic [4:0] vwr, input logic [31:0] vwd,
        input logic ch, input logic eh,
        input logic [31:0] d1, input logic [1:0] f1, input logic [31:0] d2, input logic [1:0] f2
    );
        vec_t r;
        r.rst = rst_i; r.stall = stall_i; r.rs1 = rs1; r.rs2 = rs2;
        r.rd_valid = rdv; r.issue_load = ld; r.issue_rdst = ld_rd;
        r.wb_we = wbe; r.wb_rdst = wbr; r.wb_data = wbd;
        r.vwb_we = vwe; r.vwb_rdst = vwr; r.vwb_data = vwd;
        r.chk_haz = ch; r.exp_haz = eh;
        r.exp_d1 = d1; r.exp_f1 = f1; r.exp_d2 = d2; r.exp_f2 = f2;
        return r;
    endfunction

    task automatic check(input string what, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL step %0d %s: got %h expected %h", idx, what, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check hazard mid-cycle, then operands after the edge.
    task automatic run_vec(input vec_t t, input int idx);
        rst                = t.rst;
        stall              = t.stall;
        i_rs1              = t.rs1;
        i_rs2              = t.rs2;
        i_rd_valid         = t.rd_valid;
        i_issue_load       = t.issue_load;
        i_issue_rdst       = t.issue_rdst;
        i_wb_reg_write_rf  = t.wb_we;
        i_wb_rdst          = t.wb_rdst;
        i_wb_mux           = t.wb_data;
        i_vwb_reg_write_rf = t.vwb_we;
        i_vwb_rdst         = t.vwb_rdst;
        i_vwb_mux          = t.vwb_data;
        @(negedge clk);
        if (t.chk_haz) check("o_hazard", idx, {31'd0, o_hazard}, {31'd0, t.exp_haz});
        @(posedge clk);
        #1;
        check("o_rs1_data", idx, o_rs1_data, t.exp_d1);
        check("o_rs1_fwd",  idx, {30'd0, o_rs1_fwd}, {30'd0, t.exp_f1});
        check("o_rs2_data", idx, o_rs2_data, t.exp_d2);
        check("o_rs2_fwd",  idx, {30'd0, o_rs2_fwd}, {30'd0, t.exp_f2});
    endtask

    vec_t tbl[11];

    initial begin
        //            rst st rs1 rs2 rdv ld ldrd wbe wbr wbd           vwe vwr vwd         ch eh d1            f1 d2            f2
        tbl[0]  = v(1, 0, 5,  7,  1, 1, 5,   1, 5,  32'h0000_AAAA, 1, 7,  32'h0000_BBBB, 0, 0, 32'h0,         0, 32'h0,         0);
        tbl[1]  = v(0, 0, 5,  7,  1, 0, 0,   0, 0,  32'h0,         0, 0,  32'h0,         1, 0, 32'h0,         0, 32'h0,         0);
        tbl[2]  = v(0, 0, 3,  5,  0, 0, 0,   1, 3,  32'hDEAD_BEEF, 0, 0,  32'h0,         1, 0, 32'hDEAD_BEEF, 1, 32'h0,         0);
        tbl[3]  = v(0, 0, 3,  3,  0, 0, 0,   0, 0,  32'h0,         0, 0,  32'h0,         1, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0);
        tbl[4]  = v(0, 0, 4,  3,  0, 0, 0,   1, 4,  32'h11,        1, 4,  32'h22,        1, 0, 32'h11,        1, 32'hDEAD_BEEF, 0);
        tbl[5]  = v(0, 0, 4,  4,  0, 0, 0,   0, 0,  32'h0,         1, 4,  32'h22,        1, 0, 32'h22,        2, 32'h22,        2);
        tbl[6]  = v(0, 0, 4,  0,  0, 0, 0,   0, 0,  32'h0,         0, 0,  32'h0,         1, 0, 32'h11,        0, 32'h0,         3);
        tbl[7]  = v(0, 0, 0,  0,  0, 0, 0,   1, 0,  32'hFFFF_FFFF, 1, 0,  32'h77,        1, 0, 32'h0,         3, 32'h0,         3);
        tbl[8]  = v(0, 0, 0,  31, 0, 0, 0,   0, 0,  32'h0,         0, 0,  32'h0,         1, 0, 32'h0,         3, 32'h0,         0);
        tbl[9]  = v(0, 0, 31, 31, 0, 0, 0,   1, 31, 32'h8000_0001, 1, 30, 32'h5,         1, 0, 32'h8000_0001, 1, 32'h8000_0001, 1);
        tbl[10] = v(0, 0, 31, 30, 0, 0, 0,   0, 0,  32'h0,         1, 31, 32'h99,        1, 0, 32'h99,        2, 32'h0,         0);

        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        // Load-use: issue, dependent read, WB bypass with re-issue, reset with pending set.
        run_vec(v(0, 0, 0,  0, 1, 1, 9,  0, 0, 32'h0,    0, 0, 32'h0, 1, 0, 32'h0,    3, 32'h0,    3), 100);
        run_vec(v(0, 0, 0,  9, 1, 0, 0,  0, 0, 32'h0,    0, 0, 32'h0, 1, 1, 32'h0,    3, 32'h0,    0), 101);
        run_vec(v(0, 0, 0,  9, 0, 0, 0,  0, 0, 32'h0,    0, 0, 32'h0, 1, 0, 32'h0,    3, 32'h0,    0), 102);
        run_vec(v(0, 0, 0,  9, 1, 1, 9,  1, 9, 32'h1234, 0, 0, 32'h0, 1, 0, 32'h0,    3, 32'h1234, 1), 103);
        run_vec(v(0, 0, 0,  9, 1, 0, 0,  0, 0, 32'h0,    0, 0, 32'h0, 1, 1, 32'h0,    3, 32'h1234, 0), 104);
        run_vec(v(0, 0, 9,  0, 1, 0, 0,  1, 9, 32'h4321, 0, 0, 32'h0, 1, 0, 32'h4321, 1, 32'h0,    3), 105);
        run_vec(v(0, 0, 9,  0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 32'h0, 1, 0, 32'h4321, 0, 32'h0,    3), 106);
        run_vec(v(0, 0, 0,  0, 1, 1, 12, 0, 0, 32'h0,    0, 0, 32'h0, 1, 0, 32'h0,    3, 32'h0,    3), 107);
        run_vec(v(0, 0, 12, 0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 32'h0, 1, 1, 32'h0,    0, 32'h0,    3), 108);
        run_vec(v(1, 1, 12, 9, 1, 1, 12, 1, 9, 32'hFF,   0, 0, 32'h0, 1, 1, 32'h0,    0, 32'h0,    0), 109);
        run_vec(v(0, 0, 12, 9, 1, 0, 0,  0, 0, 32'h0,    0, 0, 32'h0, 1, 0, 32'h0,    0, 32'h0,    0), 110);
        run_vec(v(0, 0, 3,  4, 1, 0, 0,  0, 0, 32'h0,    0, 0, 32'h0, 1, 0, 32'h0,    0, 32'h0,    0), 111);

        // Stall hold: latched addresses steer the mux, mid-stall write shows up, no scoreboard issue.
        run_vec(v(0, 0, 6, 10, 0, 0, 0,  0, 0, 32'h0,  0, 0, 32'h0, 1, 0, 32'h0,  0, 32'h0,  0), 200);
        run_vec(v(0, 1, 8, 0,  0, 1, 10, 1, 6, 32'h55, 0, 0, 32'h0, 1, 0, 32'h55, 1, 32'h0,  0), 201);
        run_vec(v(0, 1, 8, 10, 1, 0, 0,  1, 8, 32'hAB, 0, 0, 32'h0, 1, 0, 32'h55, 0, 32'h0,  0), 202);
        run_vec(v(0, 0, 8, 6,  1, 0, 0,  0, 0, 32'h0,  0, 0, 32'h0, 1, 0, 32'hAB, 0, 32'h55, 0), 203);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
